inst_fetch_queue: RTL

Instruction fetch front end that drives the address side of the instruction memory and consumes its asynchronous read data. It keeps a sequential fetch PC, issues one fetch per cycle, and buffers fetched {PC, instruction} pairs in a small FIFO. It hands them to decode over a valid/ready handshake. A redirect input (branch/jump resolution) flushes the queue and restarts fetch at a new PC.

---
 rtl/inst_fetch_queue.sv | 91 +++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end.
// Keeps a sequential fetch PC and issues one fetch per cycle.
// Buffers fetched {pc, inst} pairs in a small FIFO and hands them to decode
// over a valid/ready handshake. A redirect flushes the queue and restarts
// fetch at the new PC.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_dout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [31:0]                out_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic          push;
  logic          pop;

  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);

  // Handshake decode: a pop frees a slot, so a push is allowed while full
  // as long as the head leaves in the same cycle. Redirect blocks any push.
  always_comb begin
    pop  = out_valid & out_ready;
    push = ~redirect_valid & ((count < FULL_COUNT) | pop);
  end

  // Head outputs are forced to zero when the queue is empty.
  always_comb begin
    out_pc   = '0;
    out_inst = '0;
    if (out_valid) begin
      out_pc   = pc_mem[rd_ptr];
      out_inst = inst_mem[rd_ptr];
    end
  end

  // Queue storage is not reset; only occupied slots are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= imem_dout;
    end
  end

  // Fetch PC, pointers and occupancy; redirect overrides push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~32'd3;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
